// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-edge resync, mid-bit sampling,
// one-cycle valid/frame_err pulses.
module uart_rx #(
  parameter int bitwidth = 8,
  parameter int divisor  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxi,
  output logic [bitwidth-1:0] data,
  output logic                valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int CW = $clog2(divisor);
  localparam int NW = $clog2(bitwidth + 1);
  localparam logic [CW-1:0] HALF = CW'(divisor / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(divisor - 1);
  localparam logic [NW-1:0] NLAST = NW'(bitwidth - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHI
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NW-1:0]       nbit_q, nbit_d;
  logic [bitwidth-1:0] sh_q, sh_d;
  logic [bitwidth-1:0] data_d;
  logic                valid_d;
  logic                ferr_d;
  logic                s1, rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rxi;
      rx_s <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nbit_q    <= '0;
      sh_q      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nbit_q    <= nbit_d;
      sh_q      <= sh_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nbit_d  = nbit_q;
    sh_d    = sh_q;
    data_d  = data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d  = '0;
          nbit_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          sh_d   = {rx_s, sh_q[bitwidth-1:1]};
          cnt_d  = '0;
          nbit_d = nbit_q + 1'b1;
          if (nbit_q == NLAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          // leave at mid-stop so a back-to-back start edge is not missed
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAITHI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAITHI: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus
// glitch, framing, reset and random-stream sequences.
module tb_uart_rx;

  localparam int BW  = 8;
  localparam int DIV = 32;

  logic          clk;
  logic          rst;
  logic          rxi;
  logic [BW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          busy;

  uart_rx #(.bitwidth(BW), .divisor(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .rxi(rxi),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0;
  int n_ferr = 0;
  int last_vcyc = 0;
  int wide_err = 0;
  int both_err = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      n_valid   <= n_valid + 1;
      last_vcyc <= cyc;
      if (valid_prev) wide_err <= wide_err + 1;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (valid && frame_err) both_err <= both_err + 1;
    valid_prev <= valid;
  end

  int n_vec = 0;
  int n_err = 0;
  int t_drop = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxi = b;
    wait_cyc(DIV);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxi = 1'b0;
    t_drop = cyc;
    wait_cyc(DIV);
    for (int i = 0; i < BW; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop;
    int         gap;
    logic [7:0] dexp;
    int         vexp;
    int         fexp;
  } vec_t;

  vec_t tbl[8];
  int   vcyc[8];
  int   tdr[8];

  initial begin
    int vb, fb;
    logic [7:0] d0;
    logic [7:0] rb;
    logic [7:0] abort_byte;

    tbl[0] = '{8'hFF, 1'b1, 20, 8'hFF, 1, 0};
    tbl[1] = '{8'h55, 1'b1, 20, 8'h55, 1, 0};
    tbl[2] = '{8'hA5, 1'b1,  0, 8'hA5, 1, 0};
    tbl[3] = '{8'h3C, 1'b1, 20, 8'h3C, 1, 0};
    tbl[4] = '{8'h00, 1'b1, 20, 8'h00, 1, 0};
    tbl[5] = '{8'h81, 1'b1, 20, 8'h81, 1, 0};
    tbl[6] = '{8'h00, 1'b0, 20, 8'h81, 0, 1};
    tbl[7] = '{8'h7E, 1'b1, 20, 8'h7E, 1, 0};

    rst = 1'b0;
    rxi = 1'b1;
    wait_cyc(3);
    #1;
    check("reset_data", int'(data), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(10);

    // glitch shorter than half a bit
    vb = n_valid;
    rxi = 1'b0;
    wait_cyc(5);
    #1;
    check("glitch_busy_hi", int'(busy), 1);
    wait_cyc(3);
    rxi = 1'b1;
    wait_cyc(16);
    #1;
    check("glitch_busy_lo", int'(busy), 0);
    wait_cyc(20);
    #1;
    check("glitch_no_valid", n_valid - vb, 0);

    for (int i = 0; i < 8; i++) begin
      vb = n_valid;
      fb = n_ferr;
      send_frame(tbl[i].din, tbl[i].stop);
      tdr[i] = t_drop;
      rxi = 1'b1;
      wait_cyc(tbl[i].gap);
      #1;
      vcyc[i] = last_vcyc;
      check($sformatf("vec%0d_data", i), int'(data), int'(tbl[i].dexp));
      check($sformatf("vec%0d_valid", i), n_valid - vb, tbl[i].vexp);
      check($sformatf("vec%0d_ferr", i), n_ferr - fb, tbl[i].fexp);
    end
    check("latency_55", vcyc[1] - tdr[1], 307);
    check("b2b_spacing", vcyc[3] - vcyc[2], 320);

    // framing error with a long break
    @(negedge clk);
    vb = n_valid;
    fb = n_ferr;
    d0 = data;
    send_frame(8'h00, 1'b0);
    wait_cyc(1000);
    #1;
    check("brk_busy", int'(busy), 1);
    check("brk_ferr", n_ferr - fb, 1);
    check("brk_valid", n_valid - vb, 0);
    check("brk_data", int'(data), int'(d0));
    @(negedge clk);
    rxi = 1'b1;
    wait_cyc(5);
    #1;
    check("brk_busy_lo", int'(busy), 0);
    @(negedge clk);
    vb = n_valid;
    send_frame(8'h81, 1'b1);
    wait_cyc(20);
    #1;
    check("post_brk_data", int'(data), 'h81);
    check("post_brk_valid", n_valid - vb, 1);

    // reset during data bit 3
    @(negedge clk);
    vb = n_valid;
    fb = n_ferr;
    abort_byte = 8'h5A;
    rxi = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 3; i++) send_bit(abort_byte[i]);
    rxi = abort_byte[3];
    wait_cyc(16);
    rst = 1'b0;
    #1;
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rxi = 1'b1;
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(40);
    send_frame(8'hC3, 1'b1);
    wait_cyc(20);
    #1;
    check("post_rst_data", int'(data), 'hC3);
    check("post_rst_valid", n_valid - vb, 1);
    check("post_rst_ferr", n_ferr - fb, 0);

    // random stream, gaps including zero
    @(negedge clk);
    fb = n_ferr;
    for (int i = 0; i < 16; i++) begin
      vb = n_valid;
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1);
      rxi = 1'b1;
      wait_cyc((i % 4 == 0) ? 0 : int'($urandom_range(1, 30)));
      #1;
      check($sformatf("rnd%0d_data", i), int'(data), int'(rb));
      check($sformatf("rnd%0d_valid", i), n_valid - vb, 1);
      @(negedge clk);
    end
    wait_cyc(2);
    #1;
    check("rnd_no_ferr", n_ferr - fb, 0);
    check("valid_width", wide_err, 0);
    check("valid_ferr_excl", both_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
